// File: rtl/fetch_unit.sv
// Instruction fetch + NZCV flag stage; min fetch latency 1 cycle (valid the cycle after ack).
// Holds each instruction until the controller consumes it; no new request while holding.
module fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [11:0]       opfunc,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] link_pc,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              update_nzcv,
  input  logic [3:0]        nzcv_in,
  output logic [3:0]        nzcv
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] target_aligned;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic [ADDR_W-1:0] link_q;
  logic [3:0]        nzcv_q;
  logic              cons;
  logic              fetch_done;

  assign pc_seq         = pc + ADDR_W'(4);
  assign target_aligned = branch_target & ~ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    cons        = 1'b0;
    fetch_done  = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req   = 1'b1;
        fetch_done = imem_ack;
        if (imem_ack) state_nxt = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        cons        = instr_ready;
        if (instr_ready) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pc only moves at consumption, so it stays stable across a stalled request
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      link_q   <= '0;
      nzcv_q   <= '0;
    end else begin
      if (fetch_done) begin
        instr_q  <= imem_rdata;
        pc_out_q <= pc;
        link_q   <= pc_seq;
      end
      if (cons) begin
        pc <= pc_src ? target_aligned : pc_seq;
        if (update_nzcv) nzcv_q <= nzcv_in;
      end
    end
  end

  assign imem_addr = pc;
  assign instr     = instr_q;
  assign opfunc    = {instr_q[31:28], instr_q[27:20]};
  assign pc_out    = pc_out_q;
  assign link_pc   = link_q;
  assign nzcv      = nzcv_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: 32-bit instance for the main flow, 8-bit instance for PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 32-bit instance
  logic        rst, imem_req, imem_ack, instr_valid, instr_ready, pc_src, update_nzcv;
  logic [31:0] imem_addr, imem_rdata, instr, pc_out, link_pc, branch_target;
  logic [11:0] opfunc;
  logic [3:0]  nzcv_in, nzcv;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .opfunc(opfunc), .pc_out(pc_out),
    .link_pc(link_pc), .pc_src(pc_src), .branch_target(branch_target),
    .update_nzcv(update_nzcv), .nzcv_in(nzcv_in), .nzcv(nzcv)
  );

  // 8-bit instance starting near the top of its address space
  logic        rst_b, imem_req_b, imem_ack_b, instr_valid_b, instr_ready_b, pc_src_b, update_nzcv_b;
  logic [7:0]  imem_addr_b, pc_out_b, link_pc_b, branch_target_b;
  logic [31:0] imem_rdata_b, instr_b;
  logic [11:0] opfunc_b;
  logic [3:0]  nzcv_in_b, nzcv_b;

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFC)) dut_b (
    .clk(clk), .rst(rst_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b), .instr_valid(instr_valid_b),
    .instr_ready(instr_ready_b), .instr(instr_b), .opfunc(opfunc_b), .pc_out(pc_out_b),
    .link_pc(link_pc_b), .pc_src(pc_src_b), .branch_target(branch_target_b),
    .update_nzcv(update_nzcv_b), .nzcv_in(nzcv_in_b), .nzcv(nzcv_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0h want 0", imem_req); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h want 0", instr_valid); end
    n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_tests++; if (pc_out !== 32'h0 || link_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: pc_out %h link %h want 0 0", pc_out, link_pc); end
    n_tests++; if (nzcv !== 4'h0) begin n_fail++; $display("FAIL rst_nzcv: got %b want 0000", nzcv); end
    rst = 1'b0;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_idle_req: got %0h want 0", imem_req); end
  endtask

  task automatic test_fetch_seq();
    tick(); // IDLE -> FETCH
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: req %0h addr %h want 1 0", imem_req, imem_addr); end
    tick(); // memory answers one cycle after the request
    n_tests++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_ack: req %0h valid %0h want 1 0", imem_req, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hE080_0001;
    tick();
    imem_ack = 1'b0;
    n_tests++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL hold0: valid %0h req %0h want 1 0", instr_valid, imem_req); end
    n_tests++; if (instr !== 32'hE080_0001) begin n_fail++; $display("FAIL instr0: got %h want e0800001", instr); end
    n_tests++; if (opfunc !== 12'hE08) begin n_fail++; $display("FAIL opfunc0: got %h want e08", opfunc); end
    n_tests++; if (pc_out !== 32'h0 || link_pc !== 32'h4) begin n_fail++; $display("FAIL pc0: pc_out %h link %h want 0 4", pc_out, link_pc); end
    instr_ready = 1'b1;
    tick();
    n_tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL next4: valid %0h req %0h addr %h want 0 1 4", instr_valid, imem_req, imem_addr); end
    tick(); // ready high while not valid has no effect
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL stall4: req %0h addr %h want 1 4", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    n_tests++; if (pc_out !== 32'h4 || link_pc !== 32'h8 || opfunc !== 12'h123) begin n_fail++; $display("FAIL hold4: pc_out %h link %h opfunc %h want 4 8 123", pc_out, link_pc, opfunc); end
    tick();
    instr_ready = 1'b0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL next8: req %0h addr %h want 1 8", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hA000_0008; // ack in the same cycle as the request
    tick();
    imem_ack = 1'b0;
    n_tests++; if (instr_valid !== 1'b1 || pc_out !== 32'h8) begin n_fail++; $display("FAIL fast_ack: valid %0h pc_out %h want 1 8", instr_valid, pc_out); end
  endtask

  task automatic test_branch();
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0000_000C; tick(); imem_ack = 1'b0;
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hB000_0010; tick(); imem_ack = 1'b0;
    n_tests++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL br_setup: pc_out %h want 10", pc_out); end
    instr_ready = 1'b1; pc_src = 1'b1; branch_target = 32'h103;
    tick();
    instr_ready = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_addr: req %0h addr %h want 1 100", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hC000_0100; tick(); imem_ack = 1'b0;
    n_tests++; if (pc_out !== 32'h100 || link_pc !== 32'h104) begin n_fail++; $display("FAIL br_link: pc_out %h link %h want 100 104", pc_out, link_pc); end
  endtask

  task automatic test_flags();
    update_nzcv = 1'b1; nzcv_in = 4'b1111; pc_src = 1'b1; branch_target = 32'h200; // no cons: all ignored
    tick();
    n_tests++; if (nzcv !== 4'b0000 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL flag_nocons: nzcv %b valid %0h want 0000 1", nzcv, instr_valid); end
    pc_src = 1'b0; instr_ready = 1'b1; nzcv_in = 4'b0110;
    tick();
    instr_ready = 1'b0; update_nzcv = 1'b0; nzcv_in = 4'b0;
    n_tests++; if (nzcv !== 4'b0110 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL flag_upd: nzcv %b addr %h want 0110 104", nzcv, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hD000_0104; tick(); imem_ack = 1'b0;
    n_tests++; if (nzcv !== 4'b0110) begin n_fail++; $display("FAIL flag_hold: nzcv %b want 0110", nzcv); end
    instr_ready = 1'b1; pc_src = 1'b1; branch_target = 32'h42; update_nzcv = 1'b1; nzcv_in = 4'b1001;
    tick();
    instr_ready = 1'b0; pc_src = 1'b0; update_nzcv = 1'b0; nzcv_in = 4'b0;
    n_tests++; if (nzcv !== 4'b1001 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL flag_br: nzcv %b addr %h want 1001 40", nzcv, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h5A5A_5A5A; tick(); imem_ack = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      imem_ack   = (i == 2);
      imem_rdata = 32'hFFFF_FFFF;
      tick();
      n_tests++;
      if (instr !== 32'h5A5A_5A5A || opfunc !== 12'h5A5 || pc_out !== 32'h40 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: instr %h opfunc %h pc_out %h req %0h valid %0h want 5a5a5a5a 5a5 40 0 1",
                 i, instr, opfunc, pc_out, imem_req, instr_valid);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_wrap();
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    tick(); // IDLE -> FETCH at 0xFC
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (imem_req_b !== 1'b1 || imem_addr_b !== 8'hFC) begin
        n_fail++;
        $display("FAIL wrap_req%0d: req %0h addr %h want 1 fc", i, imem_req_b, imem_addr_b);
      end
      if (i == 3) begin imem_ack_b = 1'b1; imem_rdata_b = 32'hE000_00FC; end
      tick();
    end
    imem_ack_b = 1'b0;
    n_tests++; if (pc_out_b !== 8'hFC || link_pc_b !== 8'h00 || instr_valid_b !== 1'b1) begin n_fail++; $display("FAIL wrap_link: pc_out %h link %h valid %0h want fc 00 1", pc_out_b, link_pc_b, instr_valid_b); end
    instr_ready_b = 1'b1; tick(); instr_ready_b = 1'b0;
    n_tests++; if (imem_req_b !== 1'b1 || imem_addr_b !== 8'h00) begin n_fail++; $display("FAIL wrap_next: req %0h addr %h want 1 00", imem_req_b, imem_addr_b); end
  endtask

  task automatic test_mid_reset();
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin n_fail++; $display("FAIL mr_pre: req %0h addr %h want 1 44", imem_req, imem_addr); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++; if (imem_req !== 1'b0 || nzcv !== 4'b0000 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL mr_rst: req %0h nzcv %b valid %0h want 0 0000 0", imem_req, nzcv, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; // late ack lands in IDLE
    tick();
    imem_ack = 1'b0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL mr_refetch: req %0h addr %h valid %0h instr %h want 1 0 0 0", imem_req, imem_addr, instr_valid, instr); end
    imem_ack = 1'b1; imem_rdata = 32'h1357_9BDF; tick(); imem_ack = 1'b0;
    n_tests++; if (instr !== 32'h1357_9BDF || pc_out !== 32'h0 || link_pc !== 32'h4) begin n_fail++; $display("FAIL mr_data: instr %h pc_out %h link %h want 13579bdf 0 4", instr, pc_out, link_pc); end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    pc_src = 1'b0; branch_target = '0; update_nzcv = 1'b0; nzcv_in = '0;
    rst_b = 1'b1; imem_ack_b = 1'b0; imem_rdata_b = '0; instr_ready_b = 1'b0;
    pc_src_b = 1'b0; branch_target_b = '0; update_nzcv_b = 1'b0; nzcv_in_b = '0;
    test_reset();
    test_fetch_seq();
    test_branch();
    test_flags();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and flag-holding stage directly upstream of the instruction controller.
- Owns the PC and runs a req/ack handshake to instruction memory.
- Holds each fetched instruction and presents it, with its 12-bit opfunc, to the controller until the controller consumes it.
- Holds the NZCV flag register that drives the controller's nzcv input. Applies branch redirect (pc_src) and flag update (update_nzcv) at consumption.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset (word-aligned).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_W  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr/opfunc/pc_out hold a valid instruction.
- instr_ready  input  1  controller consumes the instruction this cycle.
- instr  output  32  held instruction word.
- opfunc  output  12  {instr[31:28], instr[27:20]}: cond in [11:8], op/func in [7:0].
- pc_out  output  ADDR_W  address of the held instruction.
- link_pc  output  ADDR_W  pc_out+4, the return address for branch-with-link.
- pc_src  input  1  redirect to branch_target; sampled only at consumption.
- branch_target  input  ADDR_W  redirect address; bits [1:0] forced to 0.
- update_nzcv  input  1  load nzcv_in into the flag register; sampled only at consumption.
- nzcv_in  input  4  new flags {N,Z,C,V} from the ALU.
- nzcv  output  4  current flags {N,Z,C,V} to the controller.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Consumption event: cons = instr_valid & instr_ready.
- FSM states: IDLE, FETCH, HOLD.
- Reset (rst=1 at an edge):
  - State goes to IDLE; pc=RESET_PC.
  - imem_req=0, instr_valid=0, instr=0, pc_out=0, link_pc=0, nzcv=0.
  - Reset overrides every other input in that cycle.
- IDLE: imem_req=0. Next cycle goes to FETCH unconditionally, so the first request appears 1 cycle after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc; both held stable until imem_ack.
  - On imem_ack: instr<=imem_rdata, pc_out<=pc, link_pc<=pc+4; go to HOLD.
  - An ack in the same cycle as the first request is legal, giving minimum fetch latency of 1 cycle (instr_valid rises the cycle after ack).
- HOLD:
  - instr_valid=1, imem_req=0; instr, opfunc, pc_out and link_pc held stable.
  - On cons: pc <= pc_src ? {branch_target[ADDR_W-1:2],2'b00} : pc+4; go to FETCH.
  - Without cons: remain in HOLD indefinitely.
- instr_valid is 1 only in HOLD. It drops the cycle after cons; the next instruction is valid no earlier than 2 cycles after cons.
- pc_src, branch_target, update_nzcv and nzcv_in are ignored when cons=0.
- Flags: on cons & update_nzcv, nzcv<=nzcv_in, visible the next cycle. Otherwise nzcv holds its value.
- cons with both pc_src and update_nzcv: both take effect in the same cycle.
- PC arithmetic is modulo 2^ADDR_W; pc+4 from all-ones-minus-3 wraps to 0. Same rule applies to link_pc.
- imem_ack outside FETCH (IDLE, HOLD, after reset) is ignored; no state change.
- rst during FETCH with a request outstanding: imem_req=0 the next cycle; a late ack arriving in IDLE is discarded.
- instr_ready while instr_valid=0 has no effect.

Test Plan:
- Reset release, memory acks 1 cycle after each req returning 0xE0800001 → first req at addr 0 one cycle after rst falls; instr_valid 1 cycle after ack; opfunc=0xE08; pc_out=0, link_pc=4; with instr_ready held high, next imem_addr=4, then 8.
- Branch: in HOLD with pc_out=0x10, pulse instr_ready with pc_src=1, branch_target=0x103 → next imem_addr=0x100; link_pc for that instruction=0x104.
- Flags: cons with update_nzcv=1, nzcv_in=4'b0110 → nzcv=0110 the next cycle. update_nzcv=1 with instr_ready=0 → nzcv unchanged.
- Backpressure: instr_ready low for 5 cycles in HOLD → instr, opfunc, pc_out stable; imem_req=0 throughout; stray imem_ack during HOLD ignored.
- Wrap and slow memory: ADDR_W=8, pc=0xFC, ack delayed 3 cycles → imem_req and imem_addr=0xFC held 4 cycles; link_pc=0x00; next fetch at 0x00.
- Mid-fetch reset: rst asserted while imem_req=1 and no ack → imem_req=0 and nzcv=0 the next cycle; an ack arriving during IDLE is ignored; refetch starts from RESET_PC.
